// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: RV32M funct3 codes,
// FSM state encoding and the datapath width.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_rv32m_if.sv
// Issue/write-back bundle between the register-file stage and the multiply/divide unit.
interface muldiv_rv32m_if;

  logic                         start;
  logic [2:0]                   funct3;
  logic [muldiv_pkg::XLEN-1:0]  rs1;
  logic [muldiv_pkg::XLEN-1:0]  rs2;
  logic [4:0]                   rd_addr_in;
  logic                         flush;
  logic                         busy;
  logic                         done;
  logic [muldiv_pkg::XLEN-1:0]  result;
  logic [4:0]                   rd_addr_out;
  logic                         rd_write;

  modport master (
    output start, funct3, rs1, rs2, rd_addr_in, flush,
    input  busy, done, result, rd_addr_out, rd_write
  );

  modport slave (
    input  start, funct3, rs1, rs2, rd_addr_in, flush,
    output busy, done, result, rd_addr_out, rd_write
  );

endinterface

// File: rtl/muldiv_core_step.sv
// One combinational iteration on {acc, opq}: radix-2 shift-add for multiply,
// restoring shift-subtract for divide.
module muldiv_core_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_opq,
  input  logic [XLEN-1:0] i_opb,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_opq
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  // Multiply: add multiplicand on multiplier LSB, then shift the 65-bit {carry,acc,opq} right.
  assign w_sum = {1'b0, i_acc} + (i_opq[0] ? {1'b0, i_opb} : '0);

  // Divide: partial remainder never exceeds 2*divisor, so a 32-bit subtract suffices once w_ge holds.
  assign w_shift = {i_acc, i_opq[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opb});
  assign w_sub   = w_shift[XLEN-1:0] - i_opb;

  always_comb begin
    o_acc = '0;
    o_opq = '0;
    if (i_div) begin
      o_acc = w_ge ? w_sub : w_shift[XLEN-1:0];
      o_opq = {i_opq[XLEN-2:0], w_ge};
    end else begin
      o_acc = w_sum[XLEN:1];
      o_opq = {w_sum[0], i_opq[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_rv32m.sv
// Iterative RV32M execute unit: one bit per cycle, sign fixup on magnitudes,
// single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_rv32m #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic           clock,
  input logic           reset_n,
  muldiv_rv32m_if.slave bus
);
  import muldiv_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [4:0]       r_rd_lat;
  logic [4:0]       r_rd_addr;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_opq;
  logic [XLEN-1:0]  r_opb;
  logic [XLEN-1:0]  r_result;
  logic             r_neg;
  logic             r_rem_neg;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_write;

  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_is_div;
  logic             w_div_zero;
  logic             w_ovf;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic [XLEN-1:0]  w_fast_result;
  logic [XLEN-1:0]  w_step_acc;
  logic [XLEN-1:0]  w_step_opq;
  logic [XLEN-1:0]  w_quot_fix;
  logic [XLEN-1:0]  w_rem_fix;
  logic [XLEN-1:0]  w_fix_result;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;

  always_comb begin
    w_a_signed = (bus.funct3 == OP_MUL) || (bus.funct3 == OP_MULH) ||
                 (bus.funct3 == OP_MULHSU) || (bus.funct3 == OP_DIV) ||
                 (bus.funct3 == OP_REM);
    w_b_signed = (bus.funct3 == OP_MUL) || (bus.funct3 == OP_MULH) ||
                 (bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM);
  end

  assign w_is_div   = bus.funct3[2];
  assign w_a_neg    = w_a_signed & bus.rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & bus.rs2[XLEN-1];
  assign w_mag_a    = w_a_neg ? -bus.rs1 : bus.rs1;
  assign w_mag_b    = w_b_neg ? -bus.rs2 : bus.rs2;
  assign w_div_zero = w_is_div && (bus.rs2 == '0);
  assign w_ovf      = ((bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM)) &&
                      (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero) begin
      w_fast_result = ((bus.funct3 == OP_REM) || (bus.funct3 == OP_REMU)) ? bus.rs1 : '1;
    end else if (bus.funct3 == OP_DIV) begin
      w_fast_result = {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // After a multiply {acc,opq} is the 64-bit product; after a divide opq/acc are quotient/remainder.
  assign w_prod     = {r_acc, r_opq};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_quot_fix = r_neg ? -r_opq : r_opq;
  assign w_rem_fix  = r_rem_neg ? -r_acc : r_acc;

  always_comb begin
    w_fix_result = w_rem_fix;
    case (r_op)
      OP_MUL:                       w_fix_result = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_result = w_quot_fix;
      default:                      w_fix_result = w_rem_fix;
    endcase
  end

  muldiv_core_step #(.XLEN(XLEN)) u_step (
    .i_div (r_op[2]),
    .i_acc (r_acc),
    .i_opq (r_opq),
    .i_opb (r_opb),
    .o_acc (w_step_acc),
    .o_opq (w_step_opq)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_rd_lat   <= '0;
      r_rd_addr  <= '0;
      r_acc      <= '0;
      r_opq      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
      r_neg      <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_write <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            r_op      <= bus.funct3;
            r_rd_lat  <= bus.rd_addr_in;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opq     <= w_is_div ? w_mag_a : w_mag_b;
            r_opb     <= w_is_div ? w_mag_b : w_mag_a;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_busy    <= 1'b1;
            if (w_div_zero || w_ovf) begin
              r_result   <= w_fast_result;
              r_rd_addr  <= bus.rd_addr_in;
              r_done     <= 1'b1;
              r_rd_write <= (bus.rd_addr_in != '0);
              r_state    <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_step_acc;
            r_opq <= w_step_opq;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_state <= ST_FIXUP;
            end
          end
        end
        ST_FIXUP: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_result   <= w_fix_result;
            r_rd_addr  <= r_rd_lat;
            r_done     <= 1'b1;
            r_rd_write <= (r_rd_lat != '0);
            r_state    <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.rd_addr_out = r_rd_addr;
  assign bus.rd_write    = r_rd_write;

endmodule

// File: tb/tb_muldiv_rv32m.sv
// Directed bench for muldiv_rv32m: hand-computed vectors, latency, flush,
// ignored start, mid-op reset and x0 write suppression.
module tb_muldiv_rv32m;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   cyc;
  logic seen_done;

  muldiv_rv32m_if bus ();

  muldiv_rv32m #(.XLEN(32), .CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.funct3     = f3;
    bus.rs1        = a;
    bus.rs2        = b;
    bus.rd_addr_in = rd;
    bus.start      = 1'b1;
    tick;
    bus.start = 1'b0;
    cyc       = 1;
  endtask

  task automatic wait_done;
    while (bus.done !== 1'b1 && cyc < 200) begin
      tick;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    issue(f3, a, b, rd);
    wait_done;
    $display("op %s f3=%0d rs1=0x%08h rs2=0x%08h rd=%0d -> result=0x%08h lat=%0d",
             tag, f3, a, b, rd, bus.result, cyc);
    chk({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ".result"}, bus.result, exp_res);
    chk({tag, ".rd_write"}, 32'(bus.rd_write), 32'(rd != 5'd0));
    chk({tag, ".rd_addr"}, 32'(bus.rd_addr_out), 32'(rd));
    tick;
    chk({tag, ".done_clr"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.funct3     = 3'b000;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.rd_addr_in = '0;
    repeat (3) tick;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.rd_write", 32'(bus.rd_write), 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.rd_addr", 32'(bus.rd_addr_out), 32'd0);
    reset_n = 1'b1;
    tick;

    // MUL with busy observed on the done cycle
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    chk("mul.busy_e1", 32'(bus.busy), 32'd1);
    wait_done;
    $display("op mul f3=0 rs1=0x00000007 rs2=0xfffffffd rd=5 -> result=0x%08h lat=%0d",
             bus.result, cyc);
    chk("mul.lat", 32'(cyc), 32'd34);
    chk("mul.result", bus.result, 32'hFFFF_FFEB);
    chk("mul.rd_write", 32'(bus.rd_write), 32'd1);
    chk("mul.rd_addr", 32'(bus.rd_addr_out), 32'd5);
    chk("mul.busy_done", 32'(bus.busy), 32'd1);
    tick;
    chk("mul.done_clr", 32'(bus.done), 32'd0);
    chk("mul.busy_clr", 32'(bus.busy), 32'd0);
    chk("mul.result_hold", bus.result, 32'hFFFF_FFEB);

    run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 34);
    run_op("mulhu",   3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 34);
    run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 34);
    run_op("mulhu_m", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, 34);
    run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 34);
    run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 34);
    run_op("divu",    3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 34);
    run_op("remu",    3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 34);
    run_op("divu_z",  3'b101, 32'h0000_1234, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    run_op("remu_z",  3'b111, 32'h0000_1234, 32'd0, 5'd15, 32'h0000_1234, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);

    // Flush at cycle 10 of a MUL: no done, busy drops, result keeps the previous value
    issue(3'b000, 32'd3, 32'd4, 5'd1);
    while (cyc < 10) begin
      tick;
      cyc++;
    end
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    $display("op flush f3=0 rs1=0x00000003 rs2=0x00000004 rd=1 -> flushed at cycle 10");
    chk("flush.busy", 32'(bus.busy), 32'd0);
    chk("flush.done", 32'(bus.done), 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      tick;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    chk("flush.no_done", 32'(seen_done), 32'd0);
    chk("flush.result_hold", bus.result, 32'h8000_0000);

    // Start pulsed at cycle 5 of an in-flight MUL is ignored
    issue(3'b000, 32'd6, 32'd7, 5'd3);
    while (cyc < 5) begin
      tick;
      cyc++;
    end
    bus.funct3     = 3'b100;
    bus.rs1        = 32'd1000;
    bus.rs2        = 32'd10;
    bus.rd_addr_in = 5'd9;
    bus.start      = 1'b1;
    tick;
    cyc++;
    bus.start = 1'b0;
    wait_done;
    $display("op ignore f3=0 rs1=0x00000006 rs2=0x00000007 rd=3 -> result=0x%08h lat=%0d",
             bus.result, cyc);
    chk("ignore.lat", 32'(cyc), 32'd34);
    chk("ignore.result", bus.result, 32'd42);
    chk("ignore.rd_addr", 32'(bus.rd_addr_out), 32'd3);
    // start during DONE is dropped too
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("done_start.busy", 32'(bus.busy), 32'd0);

    // flush and start together in IDLE: request dropped
    bus.funct3 = 3'b000;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    $display("op flush_start f3=0 -> dropped");
    chk("flush_start.busy", 32'(bus.busy), 32'd0);

    // Reset at cycle 20 of a DIV
    issue(3'b100, 32'd1000, 32'd10, 5'd4);
    while (cyc < 20) begin
      tick;
      cyc++;
    end
    reset_n = 1'b0;
    tick;
    $display("op reset f3=4 rs1=0x000003e8 rs2=0x0000000a rd=4 -> reset at cycle 20");
    chk("mrst.busy", 32'(bus.busy), 32'd0);
    chk("mrst.done", 32'(bus.done), 32'd0);
    chk("mrst.rd_write", 32'(bus.rd_write), 32'd0);
    chk("mrst.result", bus.result, 32'd0);
    chk("mrst.rd_addr", 32'(bus.rd_addr_out), 32'd0);
    reset_n   = 1'b1;
    seen_done = 1'b0;
    repeat (30) begin
      tick;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    chk("mrst.no_done", 32'(seen_done), 32'd0);

    // Write to x0 is suppressed
    issue(3'b000, 32'd5, 32'd5, 5'd0);
    wait_done;
    $display("op mul_x0 f3=0 rs1=0x00000005 rs2=0x00000005 rd=0 -> result=0x%08h lat=%0d",
             bus.result, cyc);
    chk("x0.done", 32'(bus.done), 32'd1);
    chk("x0.rd_write", 32'(bus.rd_write), 32'd0);
    chk("x0.result", bus.result, 32'd25);
    tick;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_rv32m.md
Name: muldiv_rv32m

Overview:
- Iterative multiply/divide execute unit for the RV32M extension.
- Sits directly downstream of the RV32I register file. Consumes the rs1/rs2 read-port data and produces write-back data and a write enable that feed the register file's rd_in / cu_rdwrite path.
- Multiply uses radix-2 shift-add; divide uses restoring shift-subtract. Each takes one bit per cycle, which keeps area small for the multi-cycle datapath.

Parameters:
- XLEN, 32, operand/result width (fixed at 32 for RV32; the parameter exists only for the bench).
- CNT_W, 6, iteration counter width (holds 0..XLEN).

Ports:
- clock  input  1  global clock, rising-edge active.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  input  1  one-cycle request strobe; honoured only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  32  operand A (dividend / multiplicand).
- rs2  input  32  operand B (divisor / multiplier).
- rd_addr_in  input  5  destination register, carried with the op.
- flush  input  1  abort the in-flight op (pipeline kill).
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse; result is valid while it is high.
- result  output  32  write-back data, connected to register file rd_in.
- rd_addr_out  output  5  latched rd_addr_in, connected to register file rd_addr.
- rd_write  output  1  equals done AND (rd_addr_out != 0), connected to cu_rdwrite.

Behaviour:
- Reset (reset_n=0 at an edge):
  - State becomes IDLE.
  - busy, done, rd_write, result, rd_addr_out and all internal registers become 0.
  - Reset takes priority over every other input, including mid-operation; an aborted op never produces done.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - start=1 at edge E0 latches funct3, rd_addr_in, the operand magnitudes and the result sign, and clears the counter.
  - Next state is CALC, or DONE on the fast path.
  - start=0: stay in IDLE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitudes are taken as two's-complement absolute values; the 64-bit product or 32-bit quotient/remainder is computed unsigned.
- CALC:
  - One iteration per edge, E1..E32; counter increments 0→32.
  - When the counter reaches XLEN, next state is FIXUP.
- FIXUP (edge E33) negates the result as needed:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Result selection: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
  - Result and rd_addr_out are registered, and next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - The next edge returns to IDLE with done=0 and busy=0.
  - A start present during DONE is ignored.
- Latency: done is high in the cycle following E33, i.e. 34 cycles after the start cycle.
- Fast path (evaluated at E0, goes straight to DONE, so done is high in the cycle after E0):
  - Divide by zero (rs2=0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Multiplies never take the fast path.
- start while busy=1: ignored; no queueing, latched operands unchanged.
- flush=1 in CALC or FIXUP: next state IDLE, no done pulse.
  - flush in DONE: done still completes this cycle.
  - flush and start together in IDLE: flush wins and the request is dropped.
- result holds its last value after DONE until the next op completes or reset.
- rd_addr_out=0 produces done=1 with rd_write=0, so a write to x0 is suppressed.
- rs1/rs2 are sampled only at E0. The register file updates its read ports on the falling edge, so the issuing stage must hold start/rs1/rs2 stable across the rising edge.

Decomposition:
- Shared package muldiv_pkg holds:
  - the funct3 localparams (OP_MUL…OP_REMU);
  - the state encodings (ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIXUP=2'd2, ST_DONE=2'd3);
  - XLEN.
- One natural sub-module, muldiv_core_step: a combinational single-iteration datapath performing either a shift-add or a shift-subtract-restore on {acc, operand}. The top module owns the FSM, counter, sign logic and the fast-path checks.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), rd=5 → done 34 cycles after start; result=0xFFFFFFEB; rd_write=1; rd_addr_out=5.
- MULH rs1=0x80000000, rs2=0x80000000 → result=0x40000000. MULHU with the same operands → result=0x40000000. MULHSU with rs1=-1, rs2=0xFFFFFFFF → result=0xFFFFFFFF.
- DIV rs1=-7, rs2=2 → result=0xFFFFFFFD (-3). REM with the same operands → result=0xFFFFFFFF (-1). DIVU rs1=100, rs2=7 → 14.
- DIVU rs1=0x1234, rs2=0 → done 1 cycle after start; result=0xFFFFFFFF. REM rs1=0x80000000, rs2=0xFFFFFFFF → result=0, latency 1.
- Start a MUL, assert flush at cycle 10 → no done pulse, busy=0 the next cycle. A start pulsed at cycle 5 of an in-flight op → ignored; the original result is still delivered.
- reset_n=0 at cycle 20 of a DIV → all outputs 0 the next cycle and no done. MUL with rd=0 → done=1, rd_write=0.
